// File: rtl/bip_fetch.sv
// BIP instruction-fetch sequencer: PC, synchronous-ROM fetch, IR latch and a FETCH/LATCH/EXEC/HALT FSM.
// Define BIP_INSTR_COUNT_EN to build the saturating executed-instruction counter on o_instr_count.
module bip_fetch #(
    parameter int unsigned PC_WIDTH      = 11,
    parameter int unsigned INSTR_WIDTH   = 16,
    parameter int unsigned OPCODE_WIDTH  = 5,
    parameter int unsigned OPERAND_WIDTH = 11
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic                     i_write_pc,
    input  logic [INSTR_WIDTH-1:0]   i_prog_data,
    output logic [PC_WIDTH-1:0]      o_prog_addr,
    output logic [OPCODE_WIDTH-1:0]  o_opcode,
    output logic [OPERAND_WIDTH-1:0] o_operand,
    output logic                     o_valid,
    output logic                     o_halted,
    output logic [15:0]              o_instr_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_EXEC,
        ST_HALT
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]  ir_q, ir_d;
    logic                    restart;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        restart = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (i_start) begin
                    restart = 1'b1;
                    pc_d    = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LATCH;
            ST_LATCH: begin
                ir_d    = i_prog_data;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // PC wraps silently modulo 2^PC_WIDTH
                if (i_write_pc) begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_prog_addr = pc_q;
    assign o_opcode    = ir_q[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign o_operand   = ir_q[OPERAND_WIDTH-1:0];
    assign o_valid     = (state_q == ST_EXEC);
    assign o_halted    = (state_q == ST_HALT);

`ifdef BIP_INSTR_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (state_q == ST_EXEC && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_instr_count = cnt_q;
`else
    assign o_instr_count = 16'h0000;
`endif

endmodule
